apb_master_bridge: RTL and testbench

- Single-outstanding APB requester that converts a simple valid/ready command port into APB SETUP/ACCESS transfers toward the wait-state-capable APB slave.
- Tolerates any number of slave wait states, with a programmable timeout abort.
- Returns read data, an error flag and the observed wait-cycle count on a one-cycle response strobe.

---
 rtl/apb_master_bridge.sv | 126 ++++++++++++
 tb/tb_apb_master_bridge.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: valid/ready command port to APB SETUP/ACCESS
// transfers, with wait-state counting and an optional timeout abort.
module apb_master_bridge #(
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned WAIT_W  = 8,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [WAIT_W-1:0] rsp_wait
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   localparam bit              TO_EN  = (TIMEOUT != 0);
   localparam logic [WAIT_W-1:0] TO_LIM = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] TO_VAL = WAIT_W'(TIMEOUT);

   state_t              state, state_nxt;
   logic [WAIT_W-1:0]   cnt, cnt_nxt;
   logic                pwrite_nxt;
   logic [ADDR_W-1:0]   paddr_nxt;
   logic [DATA_W-1:0]   pwdata_nxt;
   logic                rsp_valid_nxt;
   logic [DATA_W-1:0]   rsp_rdata_nxt;
   logic                rsp_err_nxt;
   logic [WAIT_W-1:0]   rsp_wait_nxt;

   // State register
   always_ff @(posedge pclk) begin
      if (!presetn) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      pwrite_nxt    = pwrite;
      paddr_nxt     = paddr;
      pwdata_nxt    = pwdata;
      rsp_valid_nxt = 1'b0;
      rsp_rdata_nxt = rsp_rdata;
      rsp_err_nxt   = rsp_err;
      rsp_wait_nxt  = rsp_wait;
      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               pwrite_nxt = cmd_write;
               paddr_nxt  = cmd_addr;
               pwdata_nxt = cmd_wdata;
               state_nxt  = SETUP;
            end
         end
         SETUP: begin
            cnt_nxt   = '0;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            // Completion takes priority over a timeout reached on the same edge
            if (pready) begin
               state_nxt     = IDLE;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = 1'b0;
               rsp_wait_nxt  = cnt;
               rsp_rdata_nxt = pwrite ? '0 : prdata;
            end else if (TO_EN && (cnt == TO_LIM)) begin
               state_nxt     = IDLE;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = 1'b1;
               rsp_wait_nxt  = TO_VAL;
               rsp_rdata_nxt = '0;
            end else if (cnt != {WAIT_W{1'b1}}) begin
               cnt_nxt = cnt + WAIT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Registered outputs derived from the upcoming state
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         cmd_ready <= 1'b1;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         rsp_wait  <= '0;
      end else begin
         cmd_ready <= (state_nxt == IDLE);
         psel      <= (state_nxt != IDLE);
         penable   <= (state_nxt == ACCESS);
         pwrite    <= pwrite_nxt;
         paddr     <= paddr_nxt;
         pwdata    <= pwdata_nxt;
         cnt       <= cnt_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_rdata <= rsp_rdata_nxt;
         rsp_err   <= rsp_err_nxt;
         rsp_wait  <= rsp_wait_nxt;
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a wait-state-capable APB slave model.
module tb_apb_master_bridge;

   logic       pclk;
   logic       presetn;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [3:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       psel;
   logic       penable;
   logic       pwrite;
   logic [3:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] prdata;
   logic       pready;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic [7:0] rsp_wait;

   int n_chk;
   int n_fail;

   apb_master_bridge #(.ADDR_W(4), .DATA_W(8), .WAIT_W(8), .TIMEOUT(15)) dut (
      .pclk(pclk), .presetn(presetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prdata(prdata), .pready(pready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_wait(rsp_wait)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Slave model: pready low for the first n_wait ACCESS cycles, or forever when hang
   logic [7:0]  mem [16];
   logic        hang;
   int unsigned n_wait;
   int unsigned acc_cnt = 0;

   assign pready = !hang && (acc_cnt >= n_wait);
   assign prdata = mem[paddr];

   always @(posedge pclk) begin
      if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
      else                            acc_cnt <= 0;
      if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
   end

   typedef struct {
      logic        wr;
      logic [3:0]  addr;
      logic [7:0]  wdata;
      int unsigned nw;
      logic [7:0]  rdata;
      logic        err;
      logic [7:0]  wt;
      int unsigned lat;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one command and observe it until rsp_valid (bounded)
   task automatic xfer(input logic w, input logic [3:0] a, input logic [7:0] d,
                       input int unsigned nw,
                       output logic [7:0] rd, output logic er, output logic [7:0] wt,
                       output int unsigned lat, output int unsigned pen,
                       output int unsigned pcnt, output logic stable,
                       output logic psel_rsp);
      int unsigned k;
      @(negedge pclk);
      n_wait    = nw;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      k = 0;
      while (!cmd_ready && k < 50) begin
         @(negedge pclk);
         k++;
      end
      lat = 999; pen = 0; pcnt = 0; stable = 1'b1;
      rd = 8'h00; er = 1'b0; wt = 8'h00; psel_rsp = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge pclk);
         if (c == 1) cmd_valid = 1'b0;
         if (penable) pen++;
         if (psel) pcnt++;
         if (psel && (paddr !== a || pwrite !== w || (w && pwdata !== d))) stable = 1'b0;
         if (rsp_valid) begin
            lat = c; rd = rsp_rdata; er = rsp_err; wt = rsp_wait; psel_rsp = psel;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  rd;
      logic        er;
      logic [7:0]  wt;
      int unsigned lat, pen, pcnt;
      logic        stable, psel_rsp;
      logic [5:0]  pat;
      logic        ok3, rv6;
      logic [7:0]  rd6;

      n_chk = 0; n_fail = 0;
      hang = 1'b0; n_wait = 0;
      presetn = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1;
      cmd_addr = 4'hF; cmd_wdata = 8'hFF;

      //            wr    addr   wdata  nw  rdata  err   wait  lat
      vecs[0] = '{1'b1, 4'h3, 8'hA5, 0,  8'h00, 1'b0, 8'd0,  3};
      vecs[1] = '{1'b0, 4'h3, 8'h00, 0,  8'hA5, 1'b0, 8'd0,  3};
      vecs[2] = '{1'b1, 4'h7, 8'h3C, 4,  8'h00, 1'b0, 8'd4,  7};
      vecs[3] = '{1'b0, 4'h7, 8'h00, 2,  8'h3C, 1'b0, 8'd2,  5};
      vecs[4] = '{1'b0, 4'h3, 8'h00, 14, 8'hA5, 1'b0, 8'd14, 17};
      vecs[5] = '{1'b1, 4'h9, 8'h5A, 1,  8'h00, 1'b0, 8'd1,  4};
      vecs[6] = '{1'b0, 4'h9, 8'h00, 0,  8'h5A, 1'b0, 8'd0,  3};

      // Reset with a command pending: must be ignored
      repeat (3) @(negedge pclk);
      check("rst_psel",      32'(psel),      32'd0);
      check("rst_penable",   32'(penable),   32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      check("rst_rsp_wait",  32'(rsp_wait),  32'd0);
      check("rst_paddr",     32'(paddr),     32'd0);
      check("rst_pwdata",    32'(pwdata),    32'd0);
      presetn = 1'b1; cmd_valid = 1'b0;
      @(negedge pclk);
      check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("post_rst_psel",      32'(psel),      32'd0);

      for (int i = 0; i < 7; i++) begin
         xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].nw,
              rd, er, wt, lat, pen, pcnt, stable, psel_rsp);
         check($sformatf("v%0d_rdata", i),   32'(rd),       32'(vecs[i].rdata));
         check($sformatf("v%0d_err", i),     32'(er),       32'(vecs[i].err));
         check($sformatf("v%0d_wait", i),    32'(wt),       32'(vecs[i].wt));
         check($sformatf("v%0d_latency", i), 32'(lat),      32'(vecs[i].lat));
         check($sformatf("v%0d_penable", i), 32'(pen),      32'(vecs[i].lat - 2));
         check($sformatf("v%0d_psel", i),    32'(pcnt),     32'(vecs[i].lat - 1));
         check($sformatf("v%0d_stable", i),  32'(stable),   32'd1);
         check($sformatf("v%0d_psel_rsp", i),32'(psel_rsp), 32'd0);
      end

      // rsp fields hold after the strobe
      @(negedge pclk);
      check("hold_rsp_valid", 32'(rsp_valid), 32'd0);
      check("hold_rsp_rdata", 32'(rsp_rdata), 32'h5A);

      // Timeout abort after 15 ACCESS cycles
      hang = 1'b1;
      xfer(1'b1, 4'h5, 8'h77, 0, rd, er, wt, lat, pen, pcnt, stable, psel_rsp);
      hang = 1'b0;
      check("to_rdata",    32'(rd),       32'd0);
      check("to_err",      32'(er),       32'd1);
      check("to_wait",     32'(wt),       32'd15);
      check("to_latency",  32'(lat),      32'd17);
      check("to_penable",  32'(pen),      32'd15);
      check("to_psel_rsp", 32'(psel_rsp), 32'd0);
      xfer(1'b0, 4'h7, 8'h00, 0, rd, er, wt, lat, pen, pcnt, stable, psel_rsp);
      check("after_to_rdata", 32'(rd), 32'h3C);
      check("after_to_err",   32'(er), 32'd0);

      // Back-to-back: second command accepted on the rsp_valid cycle
      @(negedge pclk);
      n_wait = 0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h1; cmd_wdata = 8'h11;
      pat = '0; ok3 = 1'b0; rv6 = 1'b0; rd6 = 8'h00;
      for (int c = 1; c <= 6; c++) begin
         @(negedge pclk);
         if (c == 1) cmd_write = 1'b0;
         if (c == 4) cmd_valid = 1'b0;
         pat[6-c] = psel;
         if (c == 3) ok3 = rsp_valid && cmd_ready;
         if (c == 6) begin rv6 = rsp_valid; rd6 = rsp_rdata; end
      end
      check("b2b_first_done",  32'(ok3), 32'd1);
      check("b2b_psel_pat",    32'(pat), 32'b110110);
      check("b2b_rsp_valid",   32'(rv6), 32'd1);
      check("b2b_rdata",       32'(rd6), 32'h11);

      // Reset during the second ACCESS wait cycle
      @(negedge pclk);
      n_wait = 5; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h7;
      @(negedge pclk);
      cmd_valid = 1'b0;
      @(negedge pclk);
      @(negedge pclk);
      check("mid_penable", 32'(penable), 32'd1);
      presetn = 1'b0;
      @(negedge pclk);
      presetn = 1'b1;
      check("mid_rst_psel",      32'(psel),      32'd0);
      check("mid_rst_penable",   32'(penable),   32'd0);
      check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      xfer(1'b0, 4'h7, 8'h00, 0, rd, er, wt, lat, pen, pcnt, stable, psel_rsp);
      check("post_mid_rdata",   32'(rd),  32'h3C);
      check("post_mid_err",     32'(er),  32'd0);
      check("post_mid_latency", 32'(lat), 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
